fetm: RTL and testbench

//  Instruction fetch stage: owns the PC, reads one 32-bit instruction per request over a pipelined

---
 rtl/ecap5_dproc_pkg.sv | 23 ++
 rtl/fetm.sv | 147 ++++++++++++++
 tb/tb_fetm.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// rtl/ecap5_dproc_pkg.sv - shared types and constants for the fetch stage
package ecap5_dproc_pkg;

    // Fetch controller states: one bus transaction and one output entry at a time
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetm_state_t;

    // PC of the first fetch after reset release when the instantiation does not override it
    localparam logic [31:0] FETM_RESET_ADDR = 32'h0000_0000;

    // Instruction reads always cover the full word
    localparam logic [3:0] FETM_WB_SEL = 4'b1111;

    // Word-align an address; instruction fetch never uses the byte offset
    function automatic logic [31:0] fetm_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetm.sv
// rtl/fetm.sv - instruction fetch stage with pipelined Wishbone read master
module fetm
    import ecap5_dproc_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = FETM_RESET_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        output_ready_i,
    output logic        output_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_stall_i,
    input  logic        wb_ack_i
);

    fetm_state_t state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        stb_q, stb_d;
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] branch_pc;

    assign branch_pc = fetm_align(branch_target_i);

    // Next-state and registered-output decode; a redirect always retargets pc_q, and any
    // transaction already committed to the bus is marked so its data is discarded on ack
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        flush_d  = flush_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        stb_d    = stb_q;
        cyc_d    = cyc_q;
        adr_d    = adr_q;

        if (branch_i) begin
            pc_d = branch_pc;
        end

        case (state_q)
            IDLE: begin
                // The first request goes out at the pre-redirect PC, so flush it if redirected
                state_d = REQ;
                stb_d   = 1'b1;
                cyc_d   = 1'b1;
                adr_d   = pc_q;
                if (branch_i) begin
                    flush_d = 1'b1;
                end
            end
            REQ: begin
                // Address stays on the bus until accepted; acks here are not ours and ignored
                if (branch_i) begin
                    flush_d = 1'b1;
                end
                if (!wb_stall_i) begin
                    state_d = WAIT;
                    stb_d   = 1'b0;
                end
            end
            WAIT: begin
                if (wb_ack_i) begin
                    if (flush_q || branch_i) begin
                        // Stale data: drop it and immediately request from the current PC
                        flush_d = 1'b0;
                        state_d = REQ;
                        stb_d   = 1'b1;
                        cyc_d   = 1'b1;
                        adr_d   = branch_i ? branch_pc : pc_q;
                    end else begin
                        instr_d  = wb_dat_i;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        state_d  = HOLD;
                        cyc_d    = 1'b0;
                    end
                end else if (branch_i) begin
                    flush_d = 1'b1;
                end
            end
            HOLD: begin
                // A redirect kills the held instruction even if decode takes it this cycle
                if (branch_i || output_ready_i) begin
                    valid_d = 1'b0;
                    state_d = REQ;
                    stb_d   = 1'b1;
                    cyc_d   = 1'b1;
                    adr_d   = branch_i ? branch_pc : pc_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            pc_q     <= RESET_ADDR;
            flush_q  <= 1'b0;
            valid_q  <= 1'b0;
            instr_q  <= 32'd0;
            pc_out_q <= 32'd0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            adr_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            flush_q  <= flush_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            adr_q    <= adr_d;
        end
    end

    assign output_valid_o = valid_q;
    assign instr_o        = instr_q;
    assign pc_o           = pc_out_q;
    assign wb_adr_o       = adr_q;
    assign wb_stb_o       = stb_q;
    assign wb_cyc_o       = cyc_q;
    assign wb_sel_o       = FETM_WB_SEL;
    assign wb_we_o        = 1'b0;

endmodule

// File: tb/tb_fetm.sv
// tb/tb_fetm.sv - randomized self-checking bench for the fetch stage
module tb_fetm;
    localparam logic [31:0] RA = 32'h0000_0040;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        output_ready_i = 1'b0;
    logic        output_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_i = 32'd0;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_stb_o;
    logic        wb_cyc_o;
    logic        wb_stall_i = 1'b0;
    logic        wb_ack_i = 1'b0;

    fetm #(.RESET_ADDR(RA)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .branch_i(branch_i), .branch_target_i(branch_target_i),
        .output_ready_i(output_ready_i), .output_valid_o(output_valid_o), .instr_o(instr_o),
        .pc_o(pc_o), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;
    int idle_cnt = 0;
    int stall_pct, lat_max, ready_pct, branch_pct, f_ready, f_stall;
    bit f_branch = 1'b0;
    logic [31:0] f_target = 32'd0;
    bit pending = 1'b0;
    logic [31:0] pend_adr = 32'd0;
    int lat = 0;
    logic [31:0] exp_pc;
    bit prev_valid, prev_ready, prev_branch, prev_stalled;
    logic [31:0] prev_instr, prev_pc, prev_adr;
    bit want_adr_en = 1'b0;
    logic [31:0] want_adr = 32'd0;
    logic [31:0] acc_q[$];
    int hs_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // Instruction memory contents as a pure function of the word address
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic clear_prev();
        prev_valid = 1'b0; prev_ready = 1'b0; prev_branch = 1'b0; prev_stalled = 1'b0;
        prev_instr = 32'd0; prev_pc = 32'd0; prev_adr = 32'd0;
    endtask

    // One clock: check held state, drive inputs, advance slave and program-order model
    task automatic step();
        bit rdy, stl, ack, br, was_pending;
        logic [31:0] tgt;
        @(negedge clk_i);
        cyc_n++;
        if (prev_valid && !prev_branch && !prev_ready) begin
            check("valid_held", 32'(output_valid_o), 32'd1);
            check("instr_held", instr_o, prev_instr);
            check("pc_held", pc_o, prev_pc);
        end
        if (prev_valid && prev_branch) check("valid_drop_on_branch", 32'(output_valid_o), 32'd0);
        if (prev_stalled) begin
            check("stb_held_stall", 32'(wb_stb_o), 32'd1);
            check("adr_held_stall", wb_adr_o, prev_adr);
        end
        if (wb_stb_o) begin
            check("sel_const", 32'(wb_sel_o), 32'hF);
            check("we_const", 32'(wb_we_o), 32'd0);
            check("cyc_with_stb", 32'(wb_cyc_o), 32'd1);
        end

        rdy = (f_ready >= 0) ? (f_ready != 0) : ($urandom_range(99) < ready_pct);
        stl = (f_stall >= 0) ? (f_stall != 0) : ($urandom_range(99) < stall_pct);
        ack = pending && (lat == 0);
        br  = f_branch || ($urandom_range(99) < branch_pct);
        if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | $urandom_range(15);
        else tgt = $urandom & 32'h0000_0FFF;
        if (f_branch) tgt = f_target;

        output_ready_i  = rdy;
        wb_stall_i      = stl;
        wb_ack_i        = ack;
        branch_i        = br;
        branch_target_i = tgt;
        wb_dat_i        = ack ? memf(pend_adr) : $urandom;
        if (ack) check("cyc_during_ack", 32'(wb_cyc_o), 32'd1);

        if (br) begin
            exp_pc = tgt & 32'hFFFF_FFFC;
            idle_cnt = 0;
        end else if (output_valid_o && rdy) begin
            check("pc_o", pc_o, exp_pc);
            check("instr_o", instr_o, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            hs_q.push_back(cyc_n);
            idle_cnt = 0;
        end else begin
            idle_cnt++;
        end
        if (idle_cnt == 400) check("progress_timeout", 32'(idle_cnt), 32'd0);

        was_pending = pending;
        if (ack) pending = 1'b0;
        else if (pending) lat--;
        if (wb_stb_o && !stl) begin
            check("single_outstanding", 32'(was_pending), 32'd0);
            if (want_adr_en) begin
                check("accept_adr", wb_adr_o, want_adr);
                want_adr_en = 1'b0;
            end
            acc_q.push_back(wb_adr_o);
            pending  = 1'b1;
            pend_adr = wb_adr_o;
            lat      = $urandom_range(lat_max);
        end

        prev_valid   = output_valid_o;
        prev_ready   = rdy;
        prev_branch  = br;
        prev_instr   = instr_o;
        prev_pc      = pc_o;
        prev_stalled = wb_stb_o && stl;
        prev_adr     = wb_adr_o;
        f_branch     = 1'b0;
    endtask

    // Reset for two cycles; optionally present a stale ack on the release edge
    task automatic apply_reset(input bit late_ack);
        @(negedge clk_i);
        rst_ni = 1'b0;
        branch_i = 1'b0; wb_ack_i = 1'b0; wb_stall_i = 1'b0; output_ready_i = 1'b0;
        #1;
        check("rst_valid", 32'(output_valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_stb", 32'(wb_stb_o), 32'd0);
        check("rst_cyc", 32'(wb_cyc_o), 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        if (late_ack) begin
            wb_ack_i = 1'b1;
            wb_dat_i = 32'hDEAD_BEEF;
        end
        pending = 1'b0;
        exp_pc = RA;
        idle_cnt = 0;
        want_adr_en = 1'b1;
        want_adr = RA;
        clear_prev();
    endtask

    initial begin
        stall_pct = 0; lat_max = 0; ready_pct = 100; branch_pct = 0; f_ready = -1; f_stall = -1;
        exp_pc = RA;
        clear_prev();
        apply_reset(1'b0);

        // Zero-wait slave, decode always ready: three-cycle cadence from RESET_ADDR
        acc_q.delete(); hs_q.delete();
        repeat (10) step();
        if (acc_q.size() >= 3 && hs_q.size() >= 3) begin
            check("cad_adr0", acc_q[0], RA);
            check("cad_adr1", acc_q[1], RA + 32'd4);
            check("cad_adr2", acc_q[2], RA + 32'd8);
            check("cad_gap1", 32'(hs_q[1] - hs_q[0]), 32'd3);
            check("cad_gap2", 32'(hs_q[2] - hs_q[1]), 32'd3);
        end else begin
            check("cad_count", 32'(acc_q.size()), 32'd4);
        end

        // Stalled request: address held, exactly one accept after release
        f_stall = 1; acc_q.delete();
        repeat (8) step();
        check("stall_no_accept", 32'(acc_q.size()), 32'd0);
        check("stall_stb", 32'(wb_stb_o), 32'd1);
        want_adr_en = 1'b1; want_adr = exp_pc;
        f_stall = 0; acc_q.delete();
        repeat (2) step();
        check("stall_single_accept", 32'(acc_q.size()), 32'd1);

        // Decode back-pressure: output held, no new request
        f_ready = 0;
        for (int k = 0; k < 20 && !output_valid_o; k++) step();
        check("hold_reached", 32'(output_valid_o), 32'd1);
        acc_q.delete();
        repeat (4) step();
        check("hold_no_new_stb", 32'(acc_q.size()), 32'd0);
        check("hold_valid", 32'(output_valid_o), 32'd1);

        // Redirect in HOLD with ready asserted: branch wins, unaligned target aligned
        f_ready = 1; f_branch = 1'b1; f_target = 32'h0000_0203;
        step();
        want_adr_en = 1'b1; want_adr = 32'h0000_0200; f_ready = -1;
        repeat (6) step();
        check("branch_hold_fetched", 32'(want_adr_en), 32'd0);

        // Redirect while waiting for an ack: in-flight data dropped
        lat_max = 3;
        for (int k = 0; k < 40 && !(pending && lat > 0); k++) step();
        check("wait_reached", 32'(pending && lat > 0), 32'd1);
        f_branch = 1'b1; f_target = 32'h0000_0100;
        step();
        want_adr_en = 1'b1; want_adr = 32'h0000_0100;
        repeat (12) step();
        check("branch_wait_fetched", 32'(want_adr_en), 32'd0);

        // PC wrap past the top of the address space
        f_ready = 0; lat_max = 0;
        for (int k = 0; k < 20 && !output_valid_o; k++) step();
        f_branch = 1'b1; f_target = 32'hFFFF_FFFE; f_ready = -1; acc_q.delete();
        repeat (12) step();
        check("wrap_second_fetch", (acc_q.size() > 1) ? acc_q[1] : 32'h1, 32'h0);

        // Randomized mix of stalls, ack latency, back-pressure and redirects
        for (int blk = 0; blk < 30; blk++) begin
            stall_pct  = $urandom_range(60);
            lat_max    = $urandom_range(3);
            ready_pct  = 20 + $urandom_range(80);
            branch_pct = $urandom_range(6);
            repeat (100) step();
        end

        // Reset mid-WAIT followed by a late ack: ack ignored, restart at RESET_ADDR
        branch_pct = 0; lat_max = 3; stall_pct = 0; ready_pct = 100;
        for (int k = 0; k < 40 && !(pending && lat > 0); k++) step();
        check("rst_wait_reached", 32'(pending && lat > 0), 32'd1);
        apply_reset(1'b1);
        acc_q.delete();
        repeat (20) step();
        check("rst_refetch", (acc_q.size() > 0) ? acc_q[0] : ~RA, RA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
